// File: rtl/clock_monitor_pkg.sv
// Shared definitions for the clock supervisor: FSM encoding, default timing
// constants and the frequency tolerance test.
package clock_monitor_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_SETTLE    = 3'd1,
    ST_MEASURE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  localparam int WINDOW_CYCLES_DEF  = 1000;
  localparam int EXPECTED_EDGES_DEF = 50;
  localparam int TOLERANCE_DEF      = 2;
  localparam int SETTLE_CYCLES_DEF  = 64;
  localparam int CNT_W_DEF          = 8;

  // |count - expected| <= tol, evaluated on plain integers
  function automatic logic in_tolerance(input int count, input int expected, input int tol);
    int diff;
    diff = count - expected;
    if (diff < 0) diff = -diff;
    return (diff <= tol);
  endfunction

endpackage

// File: rtl/clock_monitor_edge_sync_detect.sv
// Two-flop synchronizer plus one history flop; emits a one-cycle pulse on each
// rising edge of an asynchronous input sampled as data.
module clock_monitor_edge_sync_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  // [0] = first sync stage, [1] = second sync stage, [2] = edge history
  logic [2:0] sync_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[1:0], din};
    end
  end

  assign rise = sync_reg[1] & ~sync_reg[2];

endmodule

// File: rtl/clock_monitor.sv
// Supervises a generated clock and its lock flag: sequences the downstream
// reset release and keeps checking the edge rate per measurement window.
module clock_monitor
  import clock_monitor_pkg::*;
#(
  parameter int WINDOW_CYCLES  = WINDOW_CYCLES_DEF,
  parameter int EXPECTED_EDGES = EXPECTED_EDGES_DEF,
  parameter int TOLERANCE      = TOLERANCE_DEF,
  parameter int SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mon_clk,
  input  logic             locked,
  input  logic             clear_fault,
  output logic             sys_rst,
  output logic             clk_ok,
  output logic             fault,
  output logic             meas_valid,
  output logic [CNT_W-1:0] edge_count
);

  localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_reg, state_next;
  logic [SET_W-1:0] settle_cnt_reg, settle_cnt_next;
  logic [WIN_W-1:0] win_cnt_reg, win_cnt_next;
  logic [CNT_W-1:0] edge_cnt_reg, edge_cnt_next;
  logic [CNT_W-1:0] edge_count_reg, edge_count_next;
  logic             meas_valid_reg, meas_valid_next;
  logic             sys_rst_reg, sys_rst_next;
  logic             clk_ok_reg, clk_ok_next;
  logic             fault_reg, fault_next;

  logic             rise;
  logic [CNT_W-1:0] edge_total;
  logic             win_done;
  logic             result_ok;

  clock_monitor_edge_sync_detect u_mon_sync (
    .clk   (clk),
    .reset (reset),
    .din   (mon_clk),
    .rise  (rise)
  );

  // Running count including this cycle's edge, pinned at the top value
  assign edge_total = (edge_cnt_reg == CNT_MAX) ? CNT_MAX : edge_cnt_reg + CNT_W'(rise);
  assign win_done   = (win_cnt_reg == WIN_LAST);
  assign result_ok  = in_tolerance(int'(edge_total), EXPECTED_EDGES, TOLERANCE);

  always_comb begin
    state_next      = state_reg;
    settle_cnt_next = settle_cnt_reg;
    win_cnt_next    = win_cnt_reg;
    edge_cnt_next   = edge_cnt_reg;
    edge_count_next = edge_count_reg;
    meas_valid_next = 1'b0;

    // Loss of lock beats every other event, including a window result
    if ((state_reg != ST_WAIT_LOCK) && !locked) begin
      state_next = ST_WAIT_LOCK;
    end else begin
      unique case (state_reg)
        ST_WAIT_LOCK: begin
          if (locked) begin
            state_next      = ST_SETTLE;
            settle_cnt_next = '0;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_reg == SET_LAST) begin
            state_next    = ST_MEASURE;
            win_cnt_next  = '0;
            edge_cnt_next = '0;
          end else begin
            settle_cnt_next = settle_cnt_reg + SET_W'(1);
          end
        end
        ST_MEASURE, ST_RUN: begin
          if (win_done) begin
            win_cnt_next    = '0;
            edge_cnt_next   = '0;
            edge_count_next = edge_total;
            meas_valid_next = 1'b1;
            state_next      = result_ok ? ST_RUN : ST_FAULT;
          end else begin
            win_cnt_next  = win_cnt_reg + WIN_W'(1);
            edge_cnt_next = edge_total;
          end
        end
        ST_FAULT: begin
          if (clear_fault) begin
            state_next      = ST_SETTLE;
            settle_cnt_next = '0;
          end
        end
        default: state_next = ST_WAIT_LOCK;
      endcase
    end

    // Status flags follow the state being entered so they align with meas_valid
    sys_rst_next = (state_next != ST_RUN);
    clk_ok_next  = (state_next == ST_RUN);
    fault_next   = (state_next == ST_FAULT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_WAIT_LOCK;
      settle_cnt_reg <= '0;
      win_cnt_reg    <= '0;
      edge_cnt_reg   <= '0;
      edge_count_reg <= '0;
      meas_valid_reg <= 1'b0;
      sys_rst_reg    <= 1'b1;
      clk_ok_reg     <= 1'b0;
      fault_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      settle_cnt_reg <= settle_cnt_next;
      win_cnt_reg    <= win_cnt_next;
      edge_cnt_reg   <= edge_cnt_next;
      edge_count_reg <= edge_count_next;
      meas_valid_reg <= meas_valid_next;
      sys_rst_reg    <= sys_rst_next;
      clk_ok_reg     <= clk_ok_next;
      fault_reg      <= fault_next;
    end
  end

  assign sys_rst    = sys_rst_reg;
  assign clk_ok     = clk_ok_reg;
  assign fault      = fault_reg;
  assign meas_valid = meas_valid_reg;
  assign edge_count = edge_count_reg;

endmodule

// File: tb/tb_clock_monitor.sv
// Bench for clock_monitor: scenario table plus a sample-history reference model
// compared against every DUT output on each falling clock edge.
module tb_clock_monitor;

  localparam int WIN     = 1000;
  localparam int EXP     = 50;
  localparam int TOL     = 2;
  localparam int SETTLE  = 64;
  localparam int CNT_MAX = 255;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       mon_clk = 1'b0;
  logic       locked = 1'b0;
  logic       clear_fault = 1'b0;
  logic       sys_rst, clk_ok, fault, meas_valid;
  logic [7:0] edge_count;

  int checks = 0;
  int errors = 0;

  clock_monitor #(
    .WINDOW_CYCLES  (WIN),
    .EXPECTED_EDGES (EXP),
    .TOLERANCE      (TOL),
    .SETTLE_CYCLES  (SETTLE),
    .CNT_W          (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mon_clk     (mon_clk),
    .locked      (locked),
    .clear_fault (clear_fault),
    .sys_rst     (sys_rst),
    .clk_ok      (clk_ok),
    .fault       (fault),
    .meas_valid  (meas_valid),
    .edge_count  (edge_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_range(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%0d expected=%0d..%0d t=%0t", nm, act, lo, hi, $time);
    end
  endtask

  // mon_clk source: 0 = stuck low, <0 = random half periods, else fixed period
  int gen_period = 20;
  int ph = 0;
  int half_left = 10;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (gen_period == 0) begin
        mon_clk = 1'b0;
      end else if (gen_period < 0) begin
        if (half_left <= 1) begin
          mon_clk   = ~mon_clk;
          half_left = int'($urandom_range(12, 8));
        end else begin
          half_left--;
        end
      end else begin
        ph      = (ph + 1) % gen_period;
        mon_clk = (ph < gen_period / 2);
      end
    end
  end

  // Reference model: phases with absolute deadlines; the window count is
  // recomputed from the recorded mon_clk samples (two-sample pipeline lag).
  typedef enum int {M_IDLE, M_SETTLE, M_MEAS, M_RUN, M_FAULT} mphase_t;
  mphase_t m_phase = M_IDLE;
  int      cyc = 0;
  int      t_mark = 0;
  int      m_cnt = 0;
  int      m_dev = 0;
  bit      smp [0:65535];
  bit      e_mv = 1'b0;
  int      e_ec = 0;

  function automatic int window_count(input int start);
    int n;
    n = 0;
    for (int m = start; m < start + WIN; m++) begin
      if (smp[(m - 1) % 65536] && !smp[(m - 2) % 65536]) n++;
    end
    return (n > CNT_MAX) ? CNT_MAX : n;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_phase = M_IDLE;
        e_mv    = 1'b0;
        e_ec    = 0;
      end else begin
        cyc++;
        smp[cyc % 65536] = mon_clk;
        e_mv = 1'b0;
        if (m_phase != M_IDLE && !locked) begin
          m_phase = M_IDLE;
        end else begin
          case (m_phase)
            M_IDLE: if (locked) begin m_phase = M_SETTLE; t_mark = cyc; end
            M_SETTLE: if (cyc - t_mark == SETTLE) begin m_phase = M_MEAS; t_mark = cyc; end
            M_MEAS, M_RUN: begin
              if (cyc - t_mark == WIN) begin
                m_cnt   = window_count(t_mark);
                m_dev   = (m_cnt > EXP) ? m_cnt - EXP : EXP - m_cnt;
                e_ec    = m_cnt;
                e_mv    = 1'b1;
                m_phase = (m_dev <= TOL) ? M_RUN : M_FAULT;
                t_mark  = cyc;
              end
            end
            M_FAULT: if (clear_fault) begin m_phase = M_SETTLE; t_mark = cyc; end
            default: m_phase = M_IDLE;
          endcase
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("sys_rst", int'(sys_rst), int'(m_phase != M_RUN));
      check("clk_ok", int'(clk_ok), int'(m_phase == M_RUN));
      check("fault", int'(fault), int'(m_phase == M_FAULT));
      check("meas_valid", int'(meas_valid), int'(e_mv));
      check("edge_count", int'(edge_count), e_ec);
    end
  end

  typedef struct {
    int period;
    int lck;
    int clr;
    int wait_mv;  // meas_valid pulses to wait for (0: run 'cycles' cycles)
    int cycles;   // cycle budget or fixed length
    int chk;      // compare end-of-row expectations below
    int ok;
    int flt;
    int rst;
    int ec_lo;
    int ec_hi;
  } vec_t;

  vec_t tbl [13];

  task automatic run_row(input int idx);
    vec_t v;
    int   seen;
    int   n;
    v = tbl[idx];
    gen_period  = v.period;
    locked      = (v.lck != 0);
    clear_fault = (v.clr != 0);
    @(posedge clk);
    #1;
    clear_fault = 1'b0;
    seen = 0;
    n    = 0;
    while ((v.wait_mv > 0) ? (seen < v.wait_mv && n < v.cycles) : (n < v.cycles)) begin
      @(negedge clk);
      n++;
      if (meas_valid) seen++;
      if (v.period < 0) begin
        clear_fault = ($urandom_range(199, 0) == 0);
        locked      = ($urandom_range(2999, 0) != 0);
      end
    end
    if (v.wait_mv > 0) check($sformatf("row%0d_meas_valid_seen", idx), seen, v.wait_mv);
    if (v.chk != 0) begin
      check($sformatf("row%0d_clk_ok", idx), int'(clk_ok), v.ok);
      check($sformatf("row%0d_fault", idx), int'(fault), v.flt);
      check($sformatf("row%0d_sys_rst", idx), int'(sys_rst), v.rst);
      check_range($sformatf("row%0d_edge_count", idx), int'(edge_count), v.ec_lo, v.ec_hi);
    end
    $display("row %0d period=%0d locked=%0d cycles=%0d mv=%0d sys_rst=%0b clk_ok=%0b fault=%0b edge_count=%0d",
             idx, v.period, v.lck, n, seen, sys_rst, clk_ok, fault, edge_count);
  endtask

  task automatic wait_mv(input int budget, output int seen);
    int n;
    seen = 0;
    n    = 0;
    while (seen == 0 && n < budget) begin
      @(negedge clk);
      n++;
      if (meas_valid) seen = 1;
    end
  endtask

  initial begin
    int seen;
    //          period lck clr wmv  cyc  chk ok flt rst lo   hi
    tbl[0]  = '{20,    1,  0,  1,   1200, 1, 1, 0,  0,  49,  51};
    tbl[1]  = '{20,    1,  0,  2,   2200, 1, 1, 0,  0,  49,  51};
    tbl[2]  = '{25,    1,  0,  1,   1200, 1, 0, 1,  1,  38,  42};
    tbl[3]  = '{25,    1,  0,  0,   1500, 1, 0, 1,  1,  38,  42};
    tbl[4]  = '{20,    1,  1,  1,   1200, 1, 1, 0,  0,  49,  51};
    tbl[5]  = '{20,    0,  0,  0,   20,   1, 0, 0,  1,  0,   0};
    tbl[6]  = '{2,     1,  0,  1,   1200, 1, 0, 1,  1,  255, 255};
    tbl[7]  = '{0,     1,  1,  1,   1200, 1, 0, 1,  1,  0,   0};
    tbl[8]  = '{21,    1,  1,  1,   1200, 0, 0, 0,  0,  0,   0};
    tbl[9]  = '{19,    1,  1,  1,   1200, 0, 0, 0,  0,  0,   0};
    tbl[10] = '{21,    1,  1,  1,   1200, 0, 0, 0,  0,  0,   0};
    tbl[11] = '{19,    1,  1,  1,   1200, 0, 0, 0,  0,  0,   0};
    tbl[12] = '{-1,    1,  1,  0,   6000, 0, 0, 0,  0,  0,   0};

    // Reset held with lock present: outputs must stay at reset values
    ph      = int'($urandom_range(19, 0));
    locked  = 1'b1;
    reset   = 1'b0;
    repeat (10) @(negedge clk);
    $display("reset hold sys_rst=%0b clk_ok=%0b fault=%0b edge_count=%0d", sys_rst, clk_ok, fault, edge_count);
    reset = 1'b1;

    for (int i = 0; i <= 4; i++) run_row(i);

    // Lock lost halfway through a RUN window: no result, straight to WAIT_LOCK
    repeat (WIN / 2) @(negedge clk);
    locked = 1'b0;
    @(negedge clk);
    check("drop_clk_ok", int'(clk_ok), 0);
    check("drop_sys_rst", int'(sys_rst), 1);
    check("drop_fault", int'(fault), 0);
    check("drop_meas_valid", int'(meas_valid), 0);
    locked = 1'b1;
    wait_mv(SETTLE + WIN + 100, seen);
    check("relock_meas_valid_seen", seen, 1);
    check("relock_clk_ok", int'(clk_ok), 1);
    $display("lock drop/relock seen=%0d clk_ok=%0b edge_count=%0d", seen, clk_ok, edge_count);

    // Asynchronous reset in the middle of MEASURE
    locked = 1'b0;
    @(negedge clk);
    locked = 1'b1;
    repeat (SETTLE + 400) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("areset_sys_rst", int'(sys_rst), 1);
    check("areset_clk_ok", int'(clk_ok), 0);
    check("areset_fault", int'(fault), 0);
    check("areset_meas_valid", int'(meas_valid), 0);
    check("areset_edge_count", int'(edge_count), 0);
    $display("async reset sys_rst=%0b clk_ok=%0b fault=%0b edge_count=%0d", sys_rst, clk_ok, fault, edge_count);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    for (int i = 5; i < 13; i++) run_row(i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_monitor.md
Name: clock_monitor

Overview:
- Supervises the 5 MHz clock and MMCM lock indication delivered by the clock generator.
- Runs in the 100 MHz board-clock domain.
- Releases a sequenced downstream reset only after lock has held stable and the monitored clock frequency has been measured within tolerance.
- Continues measuring afterwards and flags a fault if the clock drifts or stops; the accelerometer driver logic is held in reset on fault.

Parameters:
- WINDOW_CYCLES, 1000, measurement window length in clk cycles (10 us at 100 MHz).
- EXPECTED_EDGES, 50, nominal mon_clk rising edges per window.
- TOLERANCE, 2, allowed absolute deviation from EXPECTED_EDGES (inclusive).
- SETTLE_CYCLES, 64, clk cycles locked must stay high before measuring.
- CNT_W, 8, width of edge_count; the counter saturates at 2^CNT_W-1.

Ports:
- clk  in  1  100 MHz reference clock.
- reset  in  1  asynchronous, active-low reset.
- mon_clk  in  1  monitored clock (clock generator clk_5MHz); used as data only, never as a clock.
- locked  in  1  lock indication, already synchronous to clk.
- clear_fault  in  1  single-cycle pulse; retries from FAULT.
- sys_rst  out  1  active-high reset for downstream logic.
- clk_ok  out  1  high in RUN only.
- fault  out  1  high in FAULT only.
- meas_valid  out  1  one-cycle pulse when edge_count updates.
- edge_count  out  CNT_W  edge count from the last completed window.

Behaviour:
- Reset (reset=0, async):
  - state=WAIT_LOCK, sys_rst=1, clk_ok=0, fault=0, meas_valid=0, edge_count=0.
  - All counters and synchronizer flops cleared.
- mon_clk input path:
  - 2-flop synchronizer, then a third flop for edge detect.
  - Rising edge = sync2 & ~sync3, 3 clk cycles of latency.
  - Edges are counted only in MEASURE and RUN.
- FSM states: WAIT_LOCK, SETTLE, MEASURE, RUN, FAULT. All outputs are registered.
- WAIT_LOCK:
  - sys_rst=1.
  - locked=1 -> SETTLE with settle counter cleared.
- SETTLE:
  - Counts clk cycles while locked=1.
  - At SETTLE_CYCLES-1 -> MEASURE, with window and edge counters cleared.
- MEASURE / RUN window:
  - Window counter runs 0..WINDOW_CYCLES-1.
  - On the terminal cycle, the edge count (including an edge detected that same cycle) is latched into edge_count on the next edge, with meas_valid=1 for that one cycle.
  - Edge counter restarts from 0, or from 1 if an edge is detected in the restart cycle; no edges are lost between windows.
- In-tolerance test: |count - EXPECTED_EDGES| <= TOLERANCE, evaluated on the latched value.
- MEASURE transitions:
  - In tolerance -> RUN; sys_rst=0 and clk_ok=1 from the same cycle meas_valid pulses.
  - Out of tolerance -> FAULT.
- RUN:
  - Keeps measuring continuously.
  - Out of tolerance -> FAULT: clk_ok=0, sys_rst=1, fault=1 in the meas_valid cycle.
- FAULT:
  - sys_rst=1, fault=1.
  - Measurement is halted and edge_count holds its value.
  - clear_fault=1 with locked=1 -> SETTLE.
- locked=0 in any state other than WAIT_LOCK:
  - Next cycle: WAIT_LOCK, sys_rst=1, clk_ok=0, fault=0.
  - The in-progress window is discarded, with no meas_valid pulse.
  - locked=0 has priority over clear_fault and over the window result in the same cycle.
- Edge counter saturation: the counter saturates at 2^CNT_W-1 and never wraps.
- Asserting reset mid-window aborts immediately to the reset values.

Decomposition:
- Shared package:
  - FSM state encoding as a typedef (3 bits).
  - Default timing constants: WINDOW_CYCLES, EXPECTED_EDGES, SETTLE_CYCLES.
  - Shared by the generator and monitor integration.
- Natural sub-module: edge_sync_detect, covering the 2-flop synchronizer plus rising-edge pulse. It is reusable for the SPI SCLK and interrupt inputs.

Test Plan:
- Reset held low for 10 cycles with locked=1 -> sys_rst=1, clk_ok=0, fault=0, edge_count=0 throughout; no meas_valid.
- Release reset, locked=1, mon_clk at 5 MHz -> SETTLE for 64 cycles, then meas_valid about 1000 cycles later with edge_count in 49..51; clk_ok=1 and sys_rst=0 in the same cycle; subsequent windows each pulse meas_valid every 1000 cycles.
- In RUN, switch mon_clk to 4 MHz -> next full window edge_count=40, fault=1, sys_rst=1, clk_ok=0; the count is then frozen.
- From FAULT, restore 5 MHz and pulse clear_fault -> SETTLE (64 cycles), then one window, then RUN with clk_ok=1.
- mon_clk stuck at 0 from start -> first window edge_count=0, fault=1.
- In RUN, drop locked mid-window (cycle 500) -> next cycle state=WAIT_LOCK, sys_rst=1, clk_ok=0, no meas_valid. Re-raise locked -> full SETTLE and MEASURE sequence repeats. Async reset asserted mid-MEASURE -> outputs return to reset values immediately.
